// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII transmit framer.
// CRC_POLY is the bit-reversed form of 0x04C11DB7 for LSB-first shifting.
package gmii_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        PAD,
        FCS,
        WAIT_END,
        IFG
    } tx_state_t;

    localparam logic [7:0]  ETH_PRE  = 8'h55;
    localparam logic [7:0]  ETH_SFD  = 8'hD5;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [7:0]  MIN_IFG  = 8'd12;

endpackage

// File: rtl/gmii_tx_framer_if.sv
// AXI-stream style payload handshake feeding the GMII transmit framer.
interface gmii_tx_framer_if;

    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       s_axis_tlast;
    logic       s_axis_tuser;

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tlast,
        output s_axis_tuser,
        input  s_axis_tready
    );

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        input  s_axis_tuser,
        output s_axis_tready
    );

endinterface

// File: rtl/crc32_byte.sv
// Combinational CRC-32 update over one byte, LSB first.
module crc32_byte
    import gmii_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data_in};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        crc_out = c;
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero pad, FCS and
// inter-frame gap, with underflow and bad-frame handling.
module gmii_tx_framer
    import gmii_tx_pkg::*;
#(
    parameter bit ENABLE_PADDING   = 1'b1,
    parameter int MIN_FRAME_LENGTH = 64
) (
    input  logic            tx_clk,
    input  logic            tx_rst,
    gmii_tx_framer_if.slave s_axis,
    output logic [7:0]      gmii_txd,
    output logic            gmii_tx_en,
    output logic            gmii_tx_er,
    input  logic [7:0]      cfg_ifg,
    input  logic            cfg_tx_enable,
    output logic            start_packet,
    output logic            error_underflow
);

    localparam logic [15:0] MIN_PAY = 16'(MIN_FRAME_LENGTH - 4);

    tx_state_t   state;
    tx_state_t   state_n;
    logic [2:0]  pre_cnt;
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic [1:0]  fcs_cnt;
    logic [7:0]  ifg_cnt;
    logic [7:0]  ifg_len;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [31:0] fcs;
    logic [7:0]  crc_data;
    logic        tready;
    logic [7:0]  txd_n;
    logic        en_n;
    logic        er_n;
    logic        sp_n;
    logic        uf_n;
    logic        tvalid;
    logic        tlast;
    logic        tuser;

    assign tvalid  = s_axis.s_axis_tvalid;
    assign tlast   = s_axis.s_axis_tlast;
    assign tuser   = s_axis.s_axis_tuser;
    assign s_axis.s_axis_tready = tready;

    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign fcs     = ~crc;

    crc32_byte u_crc (
        .crc_in  (crc),
        .data_in (crc_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:
                if (cfg_tx_enable && tvalid) state_n = PREAMBLE;
            PREAMBLE:
                if (pre_cnt == 3'd7) state_n = PAYLOAD;
            PAYLOAD:
                if (!tvalid)
                    state_n = WAIT_END;
                else if (tlast) begin
                    if (tuser)
                        state_n = IFG;
                    else if (ENABLE_PADDING && cnt_inc < MIN_PAY)
                        state_n = PAD;
                    else
                        state_n = FCS;
                end
            PAD:
                if (cnt_inc >= MIN_PAY) state_n = FCS;
            FCS:
                if (fcs_cnt == 2'd3) state_n = IFG;
            WAIT_END:
                if (tvalid && tlast) state_n = IFG;
            IFG:
                if (ifg_cnt == ifg_len - 8'd2) state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
    end

    // Next values of the registered GMII outputs.
    always_comb begin
        tready   = 1'b0;
        txd_n    = 8'h00;
        en_n     = 1'b0;
        er_n     = 1'b0;
        sp_n     = 1'b0;
        uf_n     = 1'b0;
        crc_data = s_axis.s_axis_tdata;
        unique case (state)
            PREAMBLE: begin
                en_n  = 1'b1;
                txd_n = (pre_cnt == 3'd7) ? ETH_SFD : ETH_PRE;
                sp_n  = (pre_cnt == 3'd7);
            end
            PAYLOAD: begin
                tready = 1'b1;
                en_n   = 1'b1;
                if (tvalid) begin
                    txd_n = s_axis.s_axis_tdata;
                    er_n  = tlast & tuser;
                end else begin
                    er_n = 1'b1;
                    uf_n = 1'b1;
                end
            end
            PAD: begin
                en_n     = 1'b1;
                crc_data = 8'h00;
            end
            FCS: begin
                en_n  = 1'b1;
                txd_n = fcs[{fcs_cnt, 3'b000} +: 8];
            end
            WAIT_END: tready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            gmii_txd        <= 8'h00;
            gmii_tx_en      <= 1'b0;
            gmii_tx_er      <= 1'b0;
            start_packet    <= 1'b0;
            error_underflow <= 1'b0;
        end else begin
            gmii_txd        <= txd_n;
            gmii_tx_en      <= en_n;
            gmii_tx_er      <= er_n;
            start_packet    <= sp_n;
            error_underflow <= uf_n;
        end
    end

    // IFG state lasts len-1 cycles; the IDLE cycle completes the gap.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            pre_cnt <= 3'd0;
            cnt     <= 16'd0;
            fcs_cnt <= 2'd0;
            ifg_cnt <= 8'd0;
            ifg_len <= 8'd0;
            crc     <= CRC_INIT;
        end else begin
            if (state == IDLE && state_n == PREAMBLE) begin
                pre_cnt <= 3'd0;
                cnt     <= 16'd0;
                crc     <= CRC_INIT;
            end else if ((state == PAYLOAD && tvalid) || state == PAD) begin
                cnt <= cnt_inc;
                crc <= crc_next;
            end
            if (state == PREAMBLE)
                pre_cnt <= pre_cnt + 3'd1;
            if (state == FCS)
                fcs_cnt <= fcs_cnt + 2'd1;
            if (state != IFG && state_n == IFG) begin
                ifg_cnt <= 8'd0;
                ifg_len <= (cfg_ifg < MIN_IFG) ? MIN_IFG : cfg_ifg;
            end else if (state == IFG) begin
                ifg_cnt <= ifg_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: padded and unpadded instances,
// frame contents, FCS, gaps, underflow, bad frame and async reset.
module tb_gmii_tx_framer;

    logic       tx_clk = 1'b0;
    logic       tx_rst = 1'b1;
    logic [7:0] cfg_ifg = 8'd12;
    logic       cfg_tx_enable = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] tdata = 8'h00;
    logic       tvalid = 1'b0;
    logic       tlast = 1'b0;
    logic       tuser = 1'b0;

    logic [7:0] txd0, txd1;
    logic       en0, en1, er0, er1, sp0, sp1, uf0, uf1;
    logic [7:0] m_txd;
    logic       m_en, m_er, m_sp, m_uf, m_rdy;

    gmii_tx_framer_if if0 ();
    gmii_tx_framer_if if1 ();

    assign if0.s_axis_tdata  = tdata;
    assign if0.s_axis_tvalid = tvalid & ~sel;
    assign if0.s_axis_tlast  = tlast;
    assign if0.s_axis_tuser  = tuser;
    assign if1.s_axis_tdata  = tdata;
    assign if1.s_axis_tvalid = tvalid & sel;
    assign if1.s_axis_tlast  = tlast;
    assign if1.s_axis_tuser  = tuser;

    gmii_tx_framer #(.ENABLE_PADDING(1'b1), .MIN_FRAME_LENGTH(64)) u0 (
        .tx_clk(tx_clk), .tx_rst(tx_rst), .s_axis(if0.slave),
        .gmii_txd(txd0), .gmii_tx_en(en0), .gmii_tx_er(er0),
        .cfg_ifg(cfg_ifg), .cfg_tx_enable(cfg_tx_enable),
        .start_packet(sp0), .error_underflow(uf0)
    );

    gmii_tx_framer #(.ENABLE_PADDING(1'b0), .MIN_FRAME_LENGTH(64)) u1 (
        .tx_clk(tx_clk), .tx_rst(tx_rst), .s_axis(if1.slave),
        .gmii_txd(txd1), .gmii_tx_en(en1), .gmii_tx_er(er1),
        .cfg_ifg(cfg_ifg), .cfg_tx_enable(cfg_tx_enable),
        .start_packet(sp1), .error_underflow(uf1)
    );

    assign m_txd = sel ? txd1 : txd0;
    assign m_en  = sel ? en1 : en0;
    assign m_er  = sel ? er1 : er0;
    assign m_sp  = sel ? sp1 : sp0;
    assign m_uf  = sel ? uf1 : uf0;
    assign m_rdy = sel ? if1.s_axis_tready : if0.s_axis_tready;

    always #5 tx_clk = ~tx_clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    logic [8:0] cap[$];
    int er_cnt, sp_cnt, uf_cnt, rdy_cnt, lowrun, last_gap;
    bit prev_en, had_frame;

    always @(negedge tx_clk) begin
        if (m_en) begin
            cap.push_back({m_er, m_txd});
            if (!prev_en && had_frame) last_gap = lowrun;
            lowrun = 0;
            had_frame = 1'b1;
        end else begin
            lowrun++;
        end
        if (m_er) er_cnt++;
        if (m_sp) sp_cnt++;
        if (m_uf) uf_cnt++;
        if (m_rdy) rdy_cnt++;
        prev_en = m_en;
    end

    task automatic clear_stats();
        cap.delete();
        er_cnt = 0; sp_cnt = 0; uf_cnt = 0; rdy_cnt = 0;
        lowrun = 0; last_gap = -1;
        prev_en = 1'b0; had_frame = 1'b0;
    endtask

    logic [7:0] sbuf [0:127];
    logic [7:0] ebuf [0:127];

    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic send(input int n, input bit bad, input int drop_at,
                        input int abort_at);
        int i = 0;
        int guard = 0;
        bit acc;
        bit dropped = 1'b0;
        tdata = sbuf[0]; tlast = (n == 1); tuser = bad && (n == 1);
        tvalid = 1'b1;
        while (i < n && guard < 2000) begin
            @(negedge tx_clk);
            acc = tvalid && m_rdy;
            @(posedge tx_clk);
            #1;
            guard++;
            if (acc) begin
                i++;
                if (abort_at > 0 && i == abort_at) begin
                    chk("pre_rst_en", {31'b0, en0}, 32'd1);
                    #2 tx_rst = 1'b1;
                    #1;
                    chk("arst_en", {31'b0, en0}, 32'd0);
                    chk("arst_txd", {24'b0, txd0}, 32'd0);
                    chk("arst_rdy", {31'b0, if0.s_axis_tready}, 32'd0);
                    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
                    repeat (3) @(posedge tx_clk);
                    #1 tx_rst = 1'b0;
                    return;
                end
                if (i < n) begin
                    tdata = sbuf[i]; tlast = (i == n - 1);
                    tuser = bad && (i == n - 1);
                end else begin
                    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
                end
                if (drop_at > 0 && i == drop_at && !dropped) begin
                    dropped = 1'b1;
                    tvalid = 1'b0;
                    @(posedge tx_clk);
                    #1 tvalid = 1'b1;
                end
            end
        end
        chk("send_done", {31'b0, guard < 2000}, 32'd1);
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    endtask

    task automatic wait_idle();
        int q = 0;
        int g = 0;
        while (q < 30 && g < 5000) begin
            @(negedge tx_clk);
            g++;
            q = m_en ? 0 : q + 1;
        end
        chk("idle_reached", {31'b0, g < 5000}, 32'd1);
        @(posedge tx_clk);
        #1;
    endtask

    task automatic check_frame(input int base, input int plen,
                               input string tag);
        int bad = 0;
        logic [31:0] c = 32'hFFFFFFFF;
        logic [8:0] b0, b1, b2, b3;
        if (cap.size() < base + plen + 12) begin
            chk({tag, "_len"}, cap.size(), base + plen + 12);
            return;
        end
        for (int k = 0; k < 7; k++)
            if (cap[base + k] !== 9'h055) bad++;
        chk({tag, "_pre"}, bad, 0);
        chk({tag, "_sfd"}, {23'b0, cap[base + 7]}, 32'h0D5);
        bad = 0;
        for (int k = 0; k < plen; k++) begin
            if (cap[base + 8 + k] !== {1'b0, ebuf[k]}) bad++;
            c = crc_step(c, ebuf[k]);
        end
        chk({tag, "_data"}, bad, 0);
        b0 = cap[base + 8 + plen];
        b1 = cap[base + 9 + plen];
        b2 = cap[base + 10 + plen];
        b3 = cap[base + 11 + plen];
        chk({tag, "_fcs"}, {b3[7:0], b2[7:0], b1[7:0], b0[7:0]}, ~c);
    endtask

    task automatic load_ramp(input int n);
        for (int k = 0; k < n; k++) begin
            sbuf[k] = 8'(k);
            ebuf[k] = 8'(k);
        end
    endtask

    initial begin
        logic [7:0] s9 [0:8];
        logic [8:0] v;
        clear_stats();
        tvalid = 1'b1;
        cfg_tx_enable = 1'b1;
        repeat (3) @(posedge tx_clk);
        #1;
        chk("rst_en", {30'b0, en0, en1}, 32'd0);
        chk("rst_txd", {16'b0, txd0, txd1}, 32'd0);
        chk("rst_er_sp_uf", {26'b0, er0, er1, sp0, sp1, uf0, uf1}, 32'd0);
        chk("rst_rdy", {30'b0, if0.s_axis_tready, if1.s_axis_tready}, 32'd0);
        tvalid = 1'b0;
        #2 tx_rst = 1'b0;
        repeat (3) @(posedge tx_clk);
        #1;
        chk("idle_no_tvalid", {31'b0, en0}, 32'd0);

        // 60-byte frame then a 1-byte padded frame back to back
        clear_stats();
        load_ramp(60);
        send(60, 1'b0, 0, 0);
        sbuf[0] = 8'hAA;
        send(1, 1'b0, 0, 0);
        wait_idle();
        chk("ab_en_cycles", cap.size(), 144);
        load_ramp(60);
        check_frame(0, 60, "a");
        ebuf[0] = 8'hAA;
        for (int k = 1; k < 60; k++) ebuf[k] = 8'h00;
        check_frame(72, 60, "b");
        chk("gap_ifg12", last_gap, 12);
        chk("ab_tready", rdy_cnt, 61);
        chk("ab_sp", sp_cnt, 2);
        chk("ab_er_uf", er_cnt + uf_cnt, 0);

        // IFG floor and IFG above the floor
        cfg_ifg = 8'd5;
        clear_stats();
        load_ramp(60);
        send(60, 1'b0, 0, 0);
        send(60, 1'b0, 0, 0);
        wait_idle();
        chk("gap_ifg5", last_gap, 12);
        chk("ifg5_en_cycles", cap.size(), 144);
        cfg_ifg = 8'd20;
        clear_stats();
        send(60, 1'b0, 0, 0);
        send(60, 1'b0, 0, 0);
        wait_idle();
        chk("gap_ifg20", last_gap, 20);
        cfg_ifg = 8'd12;

        // underflow after byte 10 of a 100-byte frame
        clear_stats();
        for (int k = 0; k < 100; k++) sbuf[k] = 8'(k + 1);
        send(100, 1'b0, 10, 0);
        wait_idle();
        chk("uf_en_cycles", cap.size(), 19);
        chk("uf_er", er_cnt, 1);
        chk("uf_pulse", uf_cnt, 1);
        if (cap.size() == 19) begin
            chk("uf_last_byte", {23'b0, cap[17]}, 32'h00A);
            chk("uf_er_cycle", {23'b0, cap[18]}, 32'h100);
        end
        chk("uf_tready", rdy_cnt, 101);

        // bad frame: tuser on tlast of a 64-byte frame
        clear_stats();
        for (int k = 0; k < 64; k++) sbuf[k] = 8'(k) ^ 8'h5A;
        send(64, 1'b1, 0, 0);
        wait_idle();
        chk("bad_en_cycles", cap.size(), 72);
        chk("bad_er", er_cnt, 1);
        chk("bad_sp", sp_cnt, 1);
        chk("bad_uf", uf_cnt, 0);
        if (cap.size() == 72) begin
            v = cap[71];
            chk("bad_last", {23'b0, v}, 32'h100 | 32'h65);
        end

        // no padding: check value of "123456789"
        sel = 1'b1;
        clear_stats();
        s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        for (int k = 0; k < 9; k++) sbuf[k] = s9[k];
        send(9, 1'b0, 0, 0);
        wait_idle();
        chk("np_en_cycles", cap.size(), 21);
        if (cap.size() == 21) begin
            chk("np_first", {23'b0, cap[8]}, 32'h031);
            chk("np_fcs0", {23'b0, cap[17]}, 32'h026);
            chk("np_fcs1", {23'b0, cap[18]}, 32'h039);
            chk("np_fcs2", {23'b0, cap[19]}, 32'h0F4);
            chk("np_fcs3", {23'b0, cap[20]}, 32'h0CB);
        end
        chk("np_er", er_cnt, 0);
        sel = 1'b0;

        // reset at payload byte 20, then a clean frame
        clear_stats();
        load_ramp(60);
        send(60, 1'b0, 0, 20);
        repeat (5) @(posedge tx_clk);
        #1;
        chk("post_rst_idle", {31'b0, en0}, 32'd0);
        clear_stats();
        send(60, 1'b0, 0, 0);
        wait_idle();
        chk("post_rst_en_cycles", cap.size(), 72);
        check_frame(0, 60, "post_rst");
        chk("post_rst_sp", sp_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gmii_tx_framer.md
GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 Parameter ENABLE_PADDING, default 1: when 1, frames shorter than MIN_FRAME_LENGTH-4 payload bytes SHALL be zero-padded.
REQ-002 Parameter MIN_FRAME_LENGTH, default 64: minimum frame length in bytes, including the 4 FCS bytes.
REQ-003 tx_clk  input  1  transmit clock; all logic is on rising edge.
REQ-004 tx_rst  input  1  reset: asynchronous, active-high.
REQ-005 s_axis_tdata  input  8  payload byte.
REQ-006 s_axis_tvalid  input  1  payload byte valid.
REQ-007 s_axis_tready  output  1  byte accepted when tvalid and tready are both high.
REQ-008 s_axis_tlast  input  1  last payload byte of the frame.
REQ-009 s_axis_tuser  input  1  bad-frame marker; sampled with tlast.
REQ-010 gmii_txd  output  8  GMII transmit data, registered.
REQ-011 gmii_tx_en  output  1  GMII transmit enable, registered.
REQ-012 gmii_tx_er  output  1  GMII transmit error, registered.
REQ-013 cfg_ifg  input  8  inter-frame gap in byte times.
REQ-014 cfg_tx_enable  input  1  permits a new frame to start.
REQ-015 start_packet  output  1  one-cycle pulse when SFD is driven.
REQ-016 error_underflow  output  1  one-cycle pulse on mid-frame underflow.

Function
REQ-017 States SHALL be IDLE, PREAMBLE, PAYLOAD, PAD, FCS, WAIT_END and IFG.
REQ-018 IDLE: gmii_tx_en=0, gmii_tx_er=0, gmii_txd=0x00, s_axis_tready=0.
- Transition to PREAMBLE when cfg_tx_enable=1 and s_axis_tvalid=1.
- cfg_tx_enable SHALL be sampled in IDLE only; deasserting it mid-frame does not stop the current frame.
REQ-019 PREAMBLE: drive 7 cycles of 0x55, then 1 cycle of 0xD5 (SFD), all with tx_en=1; start_packet=1 on the SFD cycle.
REQ-020 PAYLOAD: s_axis_tready=1; each accepted byte SHALL appear on gmii_txd exactly one cycle later with tx_en=1.
- The first payload byte directly follows the SFD with no gap.
REQ-021 Byte counter: 16 bits, saturating; cleared at PREAMBLE entry; increments per payload or pad byte output.
REQ-022 Underflow: tvalid=0 in PAYLOAD before tlast SHALL cause:
- one output cycle with tx_en=1, tx_er=1;
- error_underflow=1 for one cycle;
- transition to WAIT_END.
REQ-023 WAIT_END: tready=1; incoming bytes are discarded with tx_en=0; on tlast accepted, go to IFG; no FCS is emitted.
REQ-024 Bad frame: a byte accepted with tlast=1 and tuser=1 SHALL be driven with tx_er=1; then go to IFG with no pad and no FCS.
REQ-025 Good tlast: if ENABLE_PADDING=1 and count < MIN_FRAME_LENGTH-4, go to PAD; otherwise go to FCS.
REQ-026 PAD: drive 0x00 with tx_en=1 until count = MIN_FRAME_LENGTH-4; tready=0.
REQ-027 CRC-32 (reflected poly 0x04C11DB7, init 0xFFFFFFFF) SHALL cover payload and pad bytes.
- FCS emits the complemented CRC over 4 cycles, LSB byte first, tx_en=1.
REQ-028 IFG: tx_en=0, txd=0x00, tready=0.
- Length = max(cfg_ifg, 12) cycles, with cfg_ifg sampled on IFG entry.
- Then return to IDLE.
REQ-029 tx_er SHALL be 0 in all cycles other than those defined in REQ-022 and REQ-024.

Reset
REQ-030 While tx_rst=1, all outputs SHALL be 0 and the state SHALL be IDLE, regardless of clock activity.
REQ-031 A reset asserted mid-frame SHALL truncate the frame immediately; after release, the block waits in IDLE for a new tvalid.
REQ-032 On reset, the CRC register SHALL be set to 0xFFFFFFFF and all counters SHALL be cleared.

Structure
REQ-033 Package gmii_tx_pkg SHALL hold:
- the state enum;
- constants ETH_PRE=0x55, ETH_SFD=0xD5, CRC_POLY, CRC_INIT and MIN_IFG=12.
REQ-034 Sub-module crc32_byte: combinational one-byte CRC-32 update (crc_in, data_in -> crc_out), instantiated once.

Verification
REQ-035 60-byte frame 0x00..0x3B, cfg_ifg=12 -> 7x0x55, 0xD5, 60 data bytes, 4 FCS bytes, tx_en high 72 cycles, then exactly 12 idle cycles.
REQ-036 ENABLE_PADDING=0, payload ASCII "123456789" -> FCS bytes 0x26, 0x39, 0xF4, 0xCB; tx_en high 21 cycles.
REQ-037 1-byte frame 0xAA -> 0xAA, then 59x0x00, then FCS; tx_en high 72 cycles; tready high for 1 cycle only.
REQ-038 100-byte frame with tvalid dropped after byte 10 ->
- tx_er=1 for one cycle and error_underflow pulse;
- remaining 90 bytes drained with tx_en=0;
- no FCS, then IFG.
REQ-039 64-byte frame with tuser=1 on tlast -> tx_er=1 on byte 64 only; no FCS; start_packet pulsed once.
REQ-040 Back-to-back frames with cfg_ifg=5 -> 12-cycle gap.
- Same frames with tx_rst pulsed at payload byte 20 -> outputs 0 asynchronously; next frame starts cleanly with preamble.
